// File: rtl/handshake_elastic_fifo.sv
// handshake_elastic_fifo: circular-buffer elastic FIFO (ins/ins_valid/ins_ready -> outs/outs_valid/outs_ready) with no comb path from ins to outs or from outs_ready to ins_ready
module handshake_elastic_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);
  localparam int PW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);
  localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign ins_ready  = count != FULL;
  assign outs_valid = count != '0;
  assign outs       = mem[rd_ptr];
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ins;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
    end
  end
endmodule

// File: doc/handshake_elastic_fifo.md
HANDSHAKE_ELASTIC_FIFO -- requirements
Module: handshake_elastic_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data payload on ins and outs.
REQ-002 Parameter NUM_SLOTS, default 4, SHALL set the storage depth in tokens; legal values are integers >= 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 ins  input  DATA_WIDTH  SHALL carry the upstream token payload, for example from a constant-source stage.
REQ-006 ins_valid  input  1  SHALL indicate that the upstream token is present.
REQ-007 ins_ready  output  1  SHALL indicate that the FIFO accepts a token this cycle.
REQ-008 outs  output  DATA_WIDTH  SHALL carry the payload of the oldest stored token.
REQ-009 outs_valid  output  1  SHALL indicate that outs holds a stored token.
REQ-010 outs_ready  input  1  SHALL indicate that the downstream stage consumes the token.

Function
REQ-011 A push SHALL occur on a rising edge when ins_valid=1 and ins_ready=1; the payload is written at wr_ptr.
REQ-012 A pop SHALL occur on a rising edge when outs_valid=1 and outs_ready=1; rd_ptr then advances.
REQ-013 The block SHALL be opaque: there is no combinational path from ins to outs, nor from ins_valid to outs_valid.
- A token SHALL appear on outs no earlier than 1 cycle after its push.
REQ-014 The block SHALL break the ready path: ins_ready SHALL be a function of registered state only (ins_ready = !full), independent of outs_ready.
REQ-015 outs_valid SHALL equal !empty, and outs SHALL equal the storage entry at rd_ptr, registered or read combinationally from storage only.
REQ-016 State SHALL consist of wr_ptr, rd_ptr and count.
- count range: 0..NUM_SLOTS.
- Pointer width: clog2(NUM_SLOTS).
- empty = (count==0); full = (count==NUM_SLOTS).
REQ-017 Each pointer SHALL wrap from NUM_SLOTS-1 to 0, including when NUM_SLOTS is not a power of two.
REQ-018 Push-only SHALL increment count by 1.
- Pop-only SHALL decrement count by 1.
- Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 When full, ins_ready SHALL be 0 even if a pop occurs in the same cycle; no push SHALL occur on a full FIFO.
REQ-020 When empty, outs_valid SHALL be 0; a push in that cycle SHALL NOT be visible on outs until the next cycle.
REQ-021 Tokens SHALL leave the FIFO in arrival order, with no loss or duplication.
REQ-022 While outs_valid=1 and outs_ready=0, outs and outs_valid SHALL remain stable until a pop occurs.
REQ-023 The block SHALL ignore ins when ins_valid=0, and SHALL ignore outs_ready when outs_valid=0.

Reset
REQ-024 While rst=1, and immediately on its assertion regardless of clk, the following SHALL hold:
- wr_ptr=0, rd_ptr=0, count=0.
- All storage entries = 0.
- outs=0, outs_valid=0, ins_ready=1.
REQ-025 Reset asserted mid-operation SHALL discard all stored tokens; no token SHALL appear on outs after deassertion unless it is pushed anew.
REQ-026 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-027 Bench configuration: DATA_WIDTH=37, NUM_SLOTS=4.
REQ-028 Single token: after reset, hold ins=37'h0A163B882, ins_valid=1 for one cycle, with outs_ready=1.
- Next cycle: outs_valid=1 and outs=37'h0A163B882.
- Following cycle: outs_valid=0.
REQ-029 Fill and stall: push tokens 1,2,3,4 with outs_ready=0.
- ins_ready drops to 0 after the 4th push.
- A 5th token offered with ins_valid=1 is not accepted.
- outs holds 1 throughout.
REQ-030 Full with pop: from full, set outs_ready=1 and ins_valid=1 with token 5.
- Cycle 1: pop of token 1 only; ins_ready=0 during that cycle.
- Next cycle: ins_ready=1 and token 5 is accepted.
- Drain order: 2,3,4,5.
REQ-031 Streaming and wrap: with ins_valid=1 and outs_ready=1 continuously, push 10 sequential values 0..9.
- All values emerge in order.
- count stays <= 1.
- Pointers wrap at least twice.
REQ-032 Random backpressure: randomize ins_valid and outs_ready over 1000 cycles.
- The scoreboard sees every token exactly once, in order.
- count never exceeds 4.
- outs is stable while it is stalled.
REQ-033 Reset mid-operation: with 3 tokens stored, assert rst asynchronously between clock edges.
- outs_valid=0, ins_ready=1 and outs=0 immediately.
- After deassertion, no stale token is emitted.
